// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth/count-width derivation and threshold legality checks.
// Used by the single-clock FIFO today and intended for the clock-crossing FIFO too.
package fifo_pkg;

    localparam int AFULL_THRESH_MIN  = 1;
    localparam int AEMPTY_THRESH_MIN = 0;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so a completely full FIFO (count == depth) is representable.
    function automatic int fifo_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit afull_thresh_ok(input int thresh, input int addr_width);
        return (thresh >= AFULL_THRESH_MIN) && (thresh <= fifo_depth(addr_width));
    endfunction

    function automatic bit aempty_thresh_ok(input int thresh, input int addr_width);
        return (thresh >= AEMPTY_THRESH_MIN) && (thresh <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle of the single-clock FIFO; master drives requests.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
);
    logic                                    winc;
    logic [DATAWIDTH-1:0]                    wdata;
    logic                                    rinc;
    logic                                    clr_err;
    logic [DATAWIDTH-1:0]                    rdata;
    logic                                    wfull;
    logic                                    rempty;
    logic                                    walmost_full;
    logic                                    ralmost_empty;
    logic [fifo_count_width(ADDRWIDTH)-1:0]  count;
    logic                                    overflow;
    logic                                    underflow;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one enabled registered read port.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0] q
);
    localparam int DEPTH = fifo_depth(ADDRWIDTH);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [DATAWIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // No reset on the read register keeps it mappable onto the RAM output latch.
    always_ff @(posedge clk) begin
        if (re) begin
            q_reg <= mem[raddr];
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky error flags and an optional first-word-fall-through output stage.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int ADDRWIDTH     = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (2 ** ADDRWIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADDRWIDTH);
    localparam int CW    = fifo_count_width(ADDRWIDTH);

    if (!afull_thresh_ok(AFULL_THRESH, ADDRWIDTH)) begin : g_afull_chk
        $error("sync_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (!aempty_thresh_ok(AEMPTY_THRESH, ADDRWIDTH)) begin : g_aempty_chk
        $error("sync_fifo: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    logic [CW-1:0]        wptr_reg, rptr_reg, count_reg, count_next;
    logic                 head_vld_reg, q_vld_reg;
    logic                 overflow_reg, underflow_reg, overflow_next, underflow_next;
    logic                 full, empty, wr_acc, rd_acc, fetch;
    logic [DATAWIDTH-1:0] ram_q;

    always_comb begin
        full   = (count_reg == CW'(DEPTH));
        // In FWFT mode readability is the output register, not the count.
        empty  = (FWFT != 0) ? !head_vld_reg : (count_reg == '0);
        wr_acc = bus.winc && !full;
        rd_acc = bus.rinc && !empty;
        // FWFT refills the head whenever it is free or being popped, so pops run at full rate.
        if (FWFT != 0) begin
            fetch = (wptr_reg != rptr_reg) && (!head_vld_reg || rd_acc);
        end else begin
            fetch = rd_acc;
        end
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - 1'b1;
        end
        overflow_next  = (bus.winc && full)  ? 1'b1 : (bus.clr_err ? 1'b0 : overflow_reg);
        underflow_next = (bus.rinc && empty) ? 1'b1 : (bus.clr_err ? 1'b0 : underflow_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            head_vld_reg  <= 1'b0;
            q_vld_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (fetch) begin
                rptr_reg     <= rptr_reg + 1'b1;
                head_vld_reg <= 1'b1;
                q_vld_reg    <= 1'b1;
            end else if (rd_acc) begin
                head_vld_reg <= 1'b0;
            end
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_reg[ADDRWIDTH-1:0]),
        .wdata (bus.wdata),
        .re    (fetch),
        .raddr (rptr_reg[ADDRWIDTH-1:0]),
        .q     (ram_q)
    );

    // The RAM read register is never reset, so rdata is forced to zero until it is first loaded.
    assign bus.rdata         = q_vld_reg ? ram_q : '0;
    assign bus.count         = count_reg;
    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (count_reg >= CW'(AFULL_THRESH));
    assign bus.ralmost_empty = (count_reg <= CW'(AEMPTY_THRESH));
    assign bus.overflow      = overflow_reg;
    assign bus.underflow     = underflow_reg;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one standard-read FIFO and one FWFT FIFO sharing clock and reset.
module tb_sync_fifo;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus_s ();
    sync_fifo_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus_f ();

    sync_fifo #(.DATAWIDTH(8), .ADDRWIDTH(4), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2))
        u_std (.clk(clk), .reset_n(reset_n), .bus(bus_s));
    sync_fifo #(.DATAWIDTH(8), .ADDRWIDTH(4), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2))
        u_fwft (.clk(clk), .reset_n(reset_n), .bus(bus_f));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t std: winc=%0b rinc=%0b count=%0d rdata=%02h | fwft: winc=%0b rinc=%0b count=%0d rdata=%02h",
                 $time, bus_s.winc, bus_s.rinc, bus_s.count, bus_s.rdata,
                 bus_f.winc, bus_f.rinc, bus_f.count, bus_f.rdata);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, bus_s.count, 0);
        check({tag, "_rempty"}, bus_s.rempty, 1);
        check({tag, "_wfull"}, bus_s.wfull, 0);
        check({tag, "_aempty"}, bus_s.ralmost_empty, 1);
        check({tag, "_afull"}, bus_s.walmost_full, 0);
        check({tag, "_ovf"}, bus_s.overflow, 0);
        check({tag, "_unf"}, bus_s.underflow, 0);
        check({tag, "_rdata"}, bus_s.rdata, 0);
        check({tag, "_f_rempty"}, bus_f.rempty, 1);
        check({tag, "_f_count"}, bus_f.count, 0);
    endtask

    initial begin
        bus_s.winc = 0; bus_s.wdata = 0; bus_s.rinc = 0; bus_s.clr_err = 0;
        bus_f.winc = 0; bus_f.wdata = 0; bus_f.rinc = 0; bus_f.clr_err = 0;

        // Reset state
        tick(); tick();
        check_reset_state("rst");
        reset_n = 1'b1;

        // 1: fill 0x00..0x0F, then a rejected 17th write
        for (int i = 0; i < 16; i++) begin
            bus_s.winc = 1; bus_s.wdata = 8'(i);
            tick();
            check("fill_count", bus_s.count, i + 1);
            check("fill_afull", bus_s.walmost_full, (i + 1) >= 14);
            check("fill_wfull", bus_s.wfull, i == 15);
            check("fill_rempty", bus_s.rempty, 0);
        end
        check("fill_rdata_idle", bus_s.rdata, 0);
        bus_s.wdata = 8'h99;
        tick();
        check("ovf_count", bus_s.count, 16);
        check("ovf_flag", bus_s.overflow, 1);
        check("ovf_wfull", bus_s.wfull, 1);
        bus_s.winc = 0;

        // 2: drain in order, hold, underflow, clear
        for (int i = 0; i < 16; i++) begin
            bus_s.rinc = 1;
            tick();
            check("drain_rdata", bus_s.rdata, i);
            check("drain_count", bus_s.count, 15 - i);
            check("drain_aempty", bus_s.ralmost_empty, (15 - i) <= 2);
            check("drain_rempty", bus_s.rempty, i == 15);
            check("drain_afull", bus_s.walmost_full, (15 - i) >= 14);
        end
        bus_s.rinc = 0;
        tick();
        check("hold_rdata", bus_s.rdata, 8'h0F);
        bus_s.rinc = 1;
        tick();
        check("unf_flag", bus_s.underflow, 1);
        check("unf_ovf_sticky", bus_s.overflow, 1);
        check("unf_count", bus_s.count, 0);
        bus_s.rinc = 0; bus_s.clr_err = 1;
        tick();
        bus_s.clr_err = 0;
        check("clr_unf", bus_s.underflow, 0);
        check("clr_ovf", bus_s.overflow, 0);

        // 4: steady simultaneous traffic at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            bus_s.winc = 1; bus_s.wdata = 8'(8'h20 + i);
            tick();
        end
        check("pre_stream_count", bus_s.count, 8);
        for (int k = 0; k < 40; k++) begin
            bus_s.winc = 1; bus_s.rinc = 1; bus_s.wdata = 8'(8'h28 + k);
            tick();
            check("stream_rdata", bus_s.rdata, 8'h20 + k);
            check("stream_count", bus_s.count, 8);
        end
        bus_s.winc = 0; bus_s.rinc = 0;
        check("stream_ovf", bus_s.overflow, 0);
        check("stream_unf", bus_s.underflow, 0);

        // 5: winc+rinc when full, then when empty, then clear-vs-set priority
        for (int i = 0; i < 8; i++) begin
            bus_s.winc = 1; bus_s.wdata = 8'(8'h50 + i);
            tick();
        end
        check("full_wfull", bus_s.wfull, 1);
        bus_s.winc = 1; bus_s.rinc = 1; bus_s.wdata = 8'hEE;
        tick();
        check("fullrw_count", bus_s.count, 15);
        check("fullrw_ovf", bus_s.overflow, 1);
        check("fullrw_rdata", bus_s.rdata, 8'h48);
        check("fullrw_wfull", bus_s.wfull, 0);
        bus_s.winc = 0;
        for (int i = 0; i < 15; i++) tick();
        check("drain2_rdata", bus_s.rdata, 8'h57);
        check("drain2_count", bus_s.count, 0);
        check("drain2_rempty", bus_s.rempty, 1);
        bus_s.rinc = 0; bus_s.clr_err = 1;
        tick();
        bus_s.clr_err = 0;
        bus_s.winc = 1; bus_s.rinc = 1; bus_s.wdata = 8'h3C;
        tick();
        check("emptyrw_count", bus_s.count, 1);
        check("emptyrw_unf", bus_s.underflow, 1);
        check("emptyrw_rempty", bus_s.rempty, 0);
        check("emptyrw_rdata", bus_s.rdata, 8'h57);
        bus_s.winc = 0;
        tick();
        check("emptyrw_pop", bus_s.rdata, 8'h3C);
        check("emptyrw_count0", bus_s.count, 0);
        bus_s.clr_err = 1;
        tick();
        check("set_wins", bus_s.underflow, 1);
        bus_s.rinc = 0;
        tick();
        check("clr_only", bus_s.underflow, 0);
        bus_s.clr_err = 0;

        // 6: asynchronous reset mid-burst at count 9
        for (int i = 0; i < 9; i++) begin
            bus_s.winc = 1; bus_s.wdata = 8'(8'h60 + i);
            tick();
        end
        check("burst_count", bus_s.count, 9);
        bus_s.wdata = 8'h69;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        bus_s.winc = 0;
        tick();
        reset_n = 1'b1;
        bus_s.winc = 1; bus_s.wdata = 8'h77;
        tick();
        check("post_rst_count", bus_s.count, 1);
        bus_s.winc = 0; bus_s.rinc = 1;
        tick();
        check("post_rst_rdata", bus_s.rdata, 8'h77);
        check("post_rst_rempty", bus_s.rempty, 1);
        bus_s.rinc = 0;

        // 3: FWFT latency, pop, back-to-back pops, empty winc+rinc
        bus_f.winc = 1; bus_f.wdata = 8'hA5;
        tick();
        check("fwft_n_count", bus_f.count, 1);
        check("fwft_n_rempty", bus_f.rempty, 1);
        bus_f.winc = 0;
        tick();
        check("fwft_n1_rempty", bus_f.rempty, 0);
        check("fwft_n1_rdata", bus_f.rdata, 8'hA5);
        bus_f.rinc = 1;
        tick();
        check("fwft_pop_rempty", bus_f.rempty, 1);
        check("fwft_pop_count", bus_f.count, 0);
        bus_f.rinc = 0;
        for (int i = 0; i < 3; i++) begin
            bus_f.winc = 1; bus_f.wdata = 8'(8'hB0 + i);
            tick();
        end
        bus_f.winc = 0;
        check("fwft_head", bus_f.rdata, 8'hB0);
        check("fwft_head_count", bus_f.count, 3);
        bus_f.rinc = 1;
        tick();
        check("fwft_b2b1", bus_f.rdata, 8'hB1);
        check("fwft_b2b1_count", bus_f.count, 2);
        tick();
        check("fwft_b2b2", bus_f.rdata, 8'hB2);
        check("fwft_b2b2_rempty", bus_f.rempty, 0);
        tick();
        check("fwft_b2b_empty", bus_f.rempty, 1);
        check("fwft_b2b_count", bus_f.count, 0);
        check("fwft_unf_clean", bus_f.underflow, 0);
        bus_f.winc = 1; bus_f.rinc = 1; bus_f.wdata = 8'hC3;
        tick();
        check("fwft_rw_count", bus_f.count, 1);
        check("fwft_rw_unf", bus_f.underflow, 1);
        bus_f.winc = 0; bus_f.rinc = 0;
        tick();
        check("fwft_rw_rdata", bus_f.rdata, 8'hC3);
        check("fwft_rw_rempty", bus_f.rempty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
